// File: rtl/vedic_mac_acc.sv
// vedic_mac_acc: accumulates unsigned 9-bit products from an upstream
// 4x4 vedic multiplier into an ACC_W-bit dot-product sum.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   in_valid/in_ready   - term handshake; prod is the term, in_last ends it
//   out_valid/out_ready - result handshake
//   acc_out, term_cnt   - registered running/final sum and term count
//   ovf                 - sticky wrap flag, cleared when the result is taken
module vedic_mac_acc #(
    parameter int ACC_W     = 16,
    parameter int CNT_W     = 4,
    parameter int MAX_TERMS = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [8:0]       prod,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic [CNT_W-1:0] term_cnt,
    output logic             ovf
);

    localparam logic [0:0] S_ACCUM = 1'b0;
    localparam logic [0:0] S_DONE  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    logic             accept;
    logic [ACC_W:0]   sum;
    logic [CNT_W-1:0] cnt_inc;
    logic             hit_max;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;

        accept  = in_valid && (state_q == S_ACCUM);
        // One extra bit catches the carry out that marks a wrap.
        sum     = {1'b0, acc_q} + (ACC_W+1)'(prod);
        cnt_inc = cnt_q + CNT_W'(1);
        hit_max = (cnt_inc == CNT_W'(MAX_TERMS));

        case (state_q)
            S_ACCUM: begin
                if (accept) begin
                    acc_d = sum[ACC_W-1:0];
                    cnt_d = cnt_inc;
                    ovf_d = ovf_q | sum[ACC_W];
                    // in_last and the term limit together still end
                    // the result only once.
                    if (in_last || hit_max) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                // No bypass: a term offered now is taken next cycle.
                if (out_ready) begin
                    state_d = S_ACCUM;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: begin
                state_d = S_ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == S_ACCUM);
    assign out_valid = (state_q == S_DONE);
    assign acc_out   = acc_q;
    assign term_cnt  = cnt_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_vedic_mac_acc.sv
// tb_vedic_mac_acc: directed and randomized checks of vedic_mac_acc
// against a term-list reference model; ACC_W=16 and ACC_W=9 instances.
module tb_vedic_mac_acc;

    localparam int MAX_T = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [8:0] prod = '0;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b0;

    logic        ir_a, ov_a, ovf_a;
    logic [15:0] acc_a;
    logic [3:0]  cnt_a;
    logic        ir_b, ov_b, ovf_b;
    logic [8:0]  acc_b;
    logic [3:0]  cnt_b;

    int checks = 0;
    int errors = 0;

    int unsigned q[$];
    bit pend = 0;

    always #5 clk = ~clk;

    vedic_mac_acc #(.ACC_W(16), .CNT_W(4), .MAX_TERMS(MAX_T)) u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_a),
        .prod(prod), .in_last(in_last), .out_valid(ov_a),
        .out_ready(out_ready), .acc_out(acc_a), .term_cnt(cnt_a),
        .ovf(ovf_a)
    );

    vedic_mac_acc #(.ACC_W(9), .CNT_W(4), .MAX_TERMS(MAX_T)) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_b),
        .prod(prod), .in_last(in_last), .out_valid(ov_b),
        .out_ready(out_ready), .acc_out(acc_b), .term_cnt(cnt_b),
        .ovf(ovf_b)
    );

    function automatic int unsigned msum();
        int unsigned t = 0;
        foreach (q[i]) t += q[i];
        return t;
    endfunction

    // Apply inputs for one cycle and advance the term-list model.
    task automatic step(input bit v, input logic [8:0] p, input bit l,
                        input bit ordy, input bit r);
        in_valid = v; prod = p; in_last = l; out_ready = ordy; rst = r;
        if (r) begin
            q.delete(); pend = 0;
        end else if (pend) begin
            if (ordy) begin q.delete(); pend = 0; end
        end else if (v) begin
            q.push_back(int'(p));
            if (l || q.size() == MAX_T) pend = 1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        step(1, 9'd200, 1, 1, 1);
        step(1, 9'd17, 0, 0, 1);
        checks++;
        if (acc_a !== 16'd0 || cnt_a !== 4'd0 || ovf_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_regs acc=%0d cnt=%0d ovf=%b want 0 0 0",
                     acc_a, cnt_a, ovf_a);
        end
        checks++;
        if (ir_a !== 1'b1 || ov_a !== 1'b0 || ir_b !== 1'b1) begin
            errors++;
            $display("FAIL reset_hs in_ready=%b out_valid=%b want 1 0",
                     ir_a, ov_a);
        end
        step(0, 0, 0, 0, 0);
    endtask

    task automatic test_basic();
        step(1, 9'd3, 0, 1, 0);
        step(1, 9'd10, 0, 1, 0);
        checks++;
        if (ov_a !== 1'b0 || acc_a !== 16'd13) begin
            errors++;
            $display("FAIL basic_partial ov=%b acc=%0d want 0 13",
                     ov_a, acc_a);
        end
        step(1, 9'd225, 1, 1, 0);
        checks++;
        if (ov_a !== 1'b1 || acc_a !== 16'd238 || cnt_a !== 4'd3 ||
            ovf_a !== 1'b0) begin
            errors++;
            $display("FAIL basic_sum ov=%b acc=%0d cnt=%0d ovf=%b want 1 238 3 0",
                     ov_a, acc_a, cnt_a, ovf_a);
        end
        step(0, 0, 0, 1, 0);
        checks++;
        if (ov_a !== 1'b0 || ir_a !== 1'b1 || acc_a !== 16'd0) begin
            errors++;
            $display("FAIL basic_consume ov=%b ir=%b acc=%0d want 0 1 0",
                     ov_a, ir_a, acc_a);
        end
    endtask

    task automatic test_backpressure();
        step(1, 9'd40, 0, 0, 0);
        step(1, 9'd60, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, 9'($urandom_range(0, 225)), 1'($urandom_range(0, 1)), 0, 0);
            checks++;
            if (ir_a !== 1'b0 || ov_a !== 1'b1 || acc_a !== 16'd100 ||
                cnt_a !== 4'd2) begin
                errors++;
                $display("FAIL backpressure ir=%b ov=%b acc=%0d cnt=%0d want 0 1 100 2",
                         ir_a, ov_a, acc_a, cnt_a);
            end
        end
        step(0, 0, 0, 1, 0);
    endtask

    task automatic test_forced();
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < MAX_T; i++) begin
            step(1, 9'd225, 0, 0, 0);
            if (i == MAX_T - 2) begin
                checks++;
                if (ov_a !== 1'b0 || cnt_a !== 4'd14) begin
                    errors++;
                    $display("FAIL forced_early ov=%b cnt=%0d want 0 14",
                             ov_a, cnt_a);
                end
            end
        end
        checks++;
        if (ov_a !== 1'b1 || acc_a !== 16'd3375 || cnt_a !== 4'd15) begin
            errors++;
            $display("FAIL forced_done ov=%b acc=%0d cnt=%0d want 1 3375 15",
                     ov_a, acc_a, cnt_a);
        end
        step(0, 0, 0, 1, 0);
    endtask

    task automatic test_overflow();
        step(0, 0, 0, 0, 1);
        step(1, 9'd225, 0, 0, 0);
        step(1, 9'd225, 0, 0, 0);
        checks++;
        if (ovf_b !== 1'b0 || acc_b !== 9'd450) begin
            errors++;
            $display("FAIL ovf_before ovf=%b acc=%0d want 0 450",
                     ovf_b, acc_b);
        end
        step(1, 9'd100, 1, 0, 0);
        checks++;
        if (ov_b !== 1'b1 || acc_b !== 9'd38 || ovf_b !== 1'b1) begin
            errors++;
            $display("FAIL ovf_wrap ov=%b acc=%0d ovf=%b want 1 38 1",
                     ov_b, acc_b, ovf_b);
        end
        step(0, 0, 0, 1, 0);
        checks++;
        if (ovf_b !== 1'b0 || acc_b !== 9'd0 || ir_b !== 1'b1) begin
            errors++;
            $display("FAIL ovf_clear ovf=%b acc=%0d ir=%b want 0 0 1",
                     ovf_b, acc_b, ir_b);
        end
    endtask

    task automatic test_reset_mid();
        step(1, 9'd50, 0, 0, 0);
        step(1, 9'd70, 0, 0, 0);
        step(1, 9'd99, 1, 1, 1);
        checks++;
        if (acc_a !== 16'd0 || cnt_a !== 4'd0 || ir_a !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid acc=%0d cnt=%0d ir=%b want 0 0 1",
                     acc_a, cnt_a, ir_a);
        end
        step(1, 9'd7, 1, 0, 0);
        checks++;
        if (ov_a !== 1'b1 || acc_a !== 16'd7 || cnt_a !== 4'd1) begin
            errors++;
            $display("FAIL reset_new ov=%b acc=%0d cnt=%0d want 1 7 1",
                     ov_a, acc_a, cnt_a);
        end
    endtask

    task automatic test_back_to_back();
        int unsigned terms[3] = '{4, 9, 2};
        int unsigned want = 0;
        foreach (terms[i]) want += terms[i];
        // Result from test_reset_mid is still pending here.
        step(1, 9'd5, 1, 1, 0);
        checks++;
        if (ir_a !== 1'b1 || ov_a !== 1'b0 || acc_a !== 16'd0 ||
            cnt_a !== 4'd0) begin
            errors++;
            $display("FAIL b2b_nobypass ir=%b ov=%b acc=%0d cnt=%0d want 1 0 0 0",
                     ir_a, ov_a, acc_a, cnt_a);
        end
        step(1, 9'd5, 1, 1, 0);
        checks++;
        if (ov_a !== 1'b1 || acc_a !== 16'd5 || cnt_a !== 4'd1) begin
            errors++;
            $display("FAIL b2b_next ov=%b acc=%0d cnt=%0d want 1 5 1",
                     ov_a, acc_a, cnt_a);
        end
        step(0, 0, 0, 1, 0);
        step(1, 9'(terms[0]), 0, 0, 0);
        step(0, 9'd111, 1, 0, 0);
        step(1, 9'(terms[1]), 0, 0, 0);
        step(0, 9'd222, 1, 1, 0);
        step(0, 9'd3, 0, 0, 0);
        step(1, 9'(terms[2]), 1, 0, 0);
        checks++;
        if (ov_a !== 1'b1 || acc_a !== 16'(want) || cnt_a !== 4'd3) begin
            errors++;
            $display("FAIL bubbles ov=%b acc=%0d cnt=%0d want 1 %0d 3",
                     ov_a, acc_a, cnt_a, want);
        end
        step(0, 0, 0, 1, 0);
    endtask

    task automatic test_random();
        int unsigned s;
        step(0, 0, 0, 0, 1);
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 2) != 0), 9'($urandom_range(0, 225)),
                 1'($urandom_range(0, 6) == 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 150) == 0));
            s = msum();
            checks++;
            if (ov_a !== pend || ir_a !== !pend || ov_b !== pend ||
                ir_b !== !pend) begin
                errors++;
                $display("FAIL rnd_hs n=%0d ov=%b ir=%b want ov=%b",
                         n, ov_a, ir_a, pend);
            end
            checks++;
            if (acc_a !== 16'(s) || cnt_a !== 4'(q.size()) ||
                ovf_a !== (s >= 65536)) begin
                errors++;
                $display("FAIL rnd_a n=%0d acc=%0d cnt=%0d ovf=%b want %0d %0d",
                         n, acc_a, cnt_a, ovf_a, s % 65536, q.size());
            end
            checks++;
            if (acc_b !== 9'(s) || cnt_b !== 4'(q.size()) ||
                ovf_b !== (s >= 512)) begin
                errors++;
                $display("FAIL rnd_b n=%0d acc=%0d ovf=%b want %0d %b",
                         n, acc_b, ovf_b, s % 512, s >= 512);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_backpressure();
        test_forced();
        test_overflow();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vedic_mac_acc.md
VEDIC_MAC_ACC -- requirements
Module: vedic_mac_acc

Interface
REQ-001 SHALL have parameter ACC_W, default 16, giving accumulator and result width in bits (legal range 9..32).
REQ-002 SHALL have parameter CNT_W, default 4, giving term-counter width in bits.
REQ-003 SHALL have parameter MAX_TERMS, default 15, giving the term count that forces a result without in_last (legal range 1..2^CNT_W-1).
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1 bit: prod and in_last are valid this cycle.
REQ-007 SHALL have port in_ready, output, 1 bit: block accepts a term this cycle.
REQ-008 SHALL have port prod, input, 9 bits: unsigned product from the upstream 4x4 vedic multiplier (0..225).
REQ-009 SHALL have port in_last, input, 1 bit: the current term is the final term of the dot product.
REQ-010 SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-012 SHALL have port acc_out, output, ACC_W bits: dot-product sum.
REQ-013 SHALL have port term_cnt, output, CNT_W bits: number of terms in the result.
REQ-014 SHALL have port ovf, output, 1 bit: sticky flag that the sum wrapped past 2^ACC_W-1.

Function
REQ-015 SHALL implement two states: ACCUM (in_ready=1, out_valid=0) and DONE (in_ready=0, out_valid=1).
REQ-016 SHALL treat a term as accepted only on a cycle where in_valid=1 and in_ready=1; no term is accepted in DONE.
REQ-017 SHALL, on acceptance, register acc <= acc + zero-extended prod modulo 2^ACC_W, and term_cnt <= term_cnt+1.
REQ-018 SHALL set ovf on any accepted addition whose true sum is at least 2^ACC_W; ovf SHALL stay set until the result is consumed.
REQ-019 SHALL move from ACCUM to DONE on the edge that accepts a term with in_last=1 or accepts the term that makes term_cnt equal MAX_TERMS; out_valid SHALL assert the following cycle (latency 1 from the last term).
REQ-020 SHALL hold acc_out, term_cnt and ovf stable while in DONE with out_ready=0.
REQ-021 SHALL, on a cycle in DONE with out_ready=1, return to ACCUM on the next edge with acc, term_cnt and ovf cleared to 0; there is no same-cycle bypass of a new term.
REQ-022 SHALL drive acc_out, term_cnt and ovf directly from registers; in ACCUM they show the running partial values.
REQ-023 SHALL treat in_last and MAX_TERMS reached on the same term as a single termination.
REQ-024 SHALL, if in_valid is low, leave all state unchanged; bubbles between terms are allowed.

Reset
REQ-025 SHALL, while rst=1 at a rising edge, enter ACCUM with acc=0, term_cnt=0, ovf=0, out_valid=0 and in_ready=1, regardless of any other input.
REQ-026 SHALL discard any partial sum or pending result when rst is asserted mid-operation; reset SHALL take priority over acceptance and over result consumption.

Verification
REQ-027 SHALL verify basic sum: products 3,10,225 (last on third), out_ready=1 -> one cycle later out_valid=1, acc_out=238, term_cnt=3, ovf=0.
REQ-028 SHALL verify backpressure: result pending with out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0, acc_out is held, and no term is absorbed.
REQ-029 SHALL verify forced termination: 15 terms of 225 with in_last=0 -> DONE after the 15th term, acc_out=3375, term_cnt=15.
REQ-030 SHALL verify overflow: ACC_W=9, terms 225,225,100 (last) -> acc_out=38, ovf=1; after consumption ovf=0.
REQ-031 SHALL verify reset mid-sum: rst pulsed after 2 accepted terms -> next cycle acc_out=0, term_cnt=0, in_ready=1; a new single term 7 with last -> acc_out=7.
REQ-032 SHALL verify bubbles and back-to-back operation: terms with in_valid gaps give the same sum as gap-free input; a result consumed the same cycle a new term is offered -> that term is accepted one cycle later.
